lcd_cmd_seq: RTL and testbench
==============================

# lcd_cmd_seq

Hardware command sequencer in front of `LCD_CTRL`. It takes 4-bit display commands from a host through a small FIFO and issues them to `LCD_CTRL` one at a time, honouring `busy`. For Load commands (`cmd==0`) it streams the 108-byte 12×9 image from an external image memory. It counts the 16 `output_valid` pulses each command produces and signals completion, replacing the stimulus loop with synthesizable logic.

## Interface
- `IMG_N`, 108: image bytes streamed per Load command.
- `FIFO_DEPTH`, 4: host command FIFO entries (power of two).
- `OUT_PER_CMD`, 16: `output_valid` pulses expected per command.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `host_cmd`  in  4  command code from the host.
- `host_cmd_valid`  in  1  host command offered.
- `host_cmd_ready`  out  1  FIFO not full; a push occurs when valid && ready.
- `img_rd`  out  1  image memory read strobe.
- `img_addr`  out  7  image memory byte address, 0..IMG_N-1.
- `img_data`  in  8  image byte, valid the cycle after `img_rd`.
- `lcd_cmd`  out  4  command to `LCD_CTRL`.
- `lcd_cmd_valid`  out  1  command strobe to `LCD_CTRL`.
- `lcd_datain`  out  8  image byte to `LCD_CTRL`.
- `lcd_busy`  in  1  `LCD_CTRL` busy.
- `lcd_output_valid`  in  1  `LCD_CTRL` output strobe.
- `seq_idle`  out  1  FIFO empty and FSM in IDLE.
- `cmd_done`  out  1  one-cycle pulse per completed command.
- `err`  out  1  sticky error flag, cleared only by reset.

## Operation
- **Reset values:** all outputs 0 except `host_cmd_ready` = 1 and `seq_idle` = 1. FIFO is empty, FSM is in IDLE, counters are 0.
- **Reset mid-operation:** reset aborts any stream immediately. The FIFO is flushed.
- **FIFO:** depth `FIFO_DEPTH`. A push and a pop in the same cycle are both honoured. When the FIFO is full, `host_cmd_ready` is 0 and pushes are ignored.
- **IDLE:**
  - If the FIFO is non-empty and `lcd_busy` is 0: drive `lcd_cmd` = head, `lcd_cmd_valid` = 1 for exactly one cycle (the issue cycle), and pop.
  - If the popped command is 0, go to LOAD. Otherwise go to WAIT.
- **LOAD:**
  - `img_rd` = 1 and `img_addr` = k in issue cycle T+k, for k = 0..IMG_N-1.
  - `lcd_datain` = `img_data` in cycles T+1..T+IMG_N. `img_data` is passed through combinationally, so byte k appears at T+k+1.
  - After cycle T+IMG_N, go to WAIT.
  - `lcd_datain` = 0 whenever it is not streaming.
- **WAIT:**
  - Count `lcd_output_valid` pulses with a 5-bit counter that saturates at 31.
  - When count == `OUT_PER_CMD` and `lcd_busy` == 0: pulse `cmd_done`, clear the count, return to IDLE.
  - The next issue can occur no earlier than the cycle after `cmd_done`.
- **Error conditions (each sets `err`):**
  - `lcd_output_valid` while in IDLE or LOAD.
  - Count exceeds `OUT_PER_CMD` in WAIT.
- **Command codes** are not decoded beyond the 0/non-zero distinction. They are forwarded unchanged.

## Timing
- Host push to issue: at least 1 cycle (registered FIFO head).
- Issue to WAIT entry:
  - non-Load commands: 1 cycle.
  - Load: IMG_N+1 cycles.
- Exactly one `lcd_cmd_valid` pulse per popped command. It is never asserted while `lcd_busy` = 1.
- `cmd_done` is asserted in the cycle that the FSM transitions WAIT→IDLE.
- `seq_idle` is computed combinationally from the FSM state and the FIFO empty flag.

## Configuration
- **`LCD_SEQ_WDOG_EN` defined:** a 12-bit watchdog counts cycles spent in WAIT and clears on each `lcd_output_valid`. On reaching 4095 it does three things:
  - sets `err`,
  - flushes the FIFO,
  - forces IDLE without a `cmd_done` pulse.
- **`LCD_SEQ_WDOG_EN` not defined:** there is no watchdog, and WAIT can last indefinitely.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles. Expect `seq_idle` = 1, `host_cmd_ready` = 1, and all other outputs 0.
- **Load:** push cmd 0 with the memory model returning `img_data` = addr+1.
  - Expect `lcd_cmd_valid` for 1 cycle, then `lcd_datain` = 0x01..0x6C over 108 consecutive cycles.
  - Model returns 16 `output_valid` pulses. Expect one `cmd_done`.
- **Back-to-back:** push commands 1, 2, 3, 4 in 4 consecutive cycles, then a 5th while full.
  - Expect `host_cmd_ready` = 0 on the 5th.
  - Expect issue order 1, 2, 3, 4, with each issued only after the previous `cmd_done`.
- **Busy hold-off:** keep `lcd_busy` = 1 for 20 cycles while the FIFO is non-empty. Expect `lcd_cmd_valid` = 0 throughout and an issue in the first cycle `busy` = 0.
- **Error:** in WAIT, the model returns 17 `output_valid` pulses. Expect `err` = 1, held until reset.
- **Watchdog:** with `LCD_SEQ_WDOG_EN` defined, keep `lcd_busy` = 1 with no outputs after issuing cmd 1.
  - Expect `err` = 1 and IDLE 4095 cycles after WAIT entry, with the FIFO empty and no `cmd_done`.

Source files
------------

// File: rtl/lcd_cmd_seq_if.sv
// lcd_cmd_seq_if: groups the host command handshake, the image memory read
// port and the LCD_CTRL command/data/status signals used by lcd_cmd_seq.
//   slave  : the sequencer side (lcd_cmd_seq)
//   master : the environment side (host, image memory, LCD_CTRL)
// Signals:
//   host_cmd[3:0], host_cmd_valid, host_cmd_ready   host command push
//   img_rd, img_addr[6:0], img_data[7:0]            image memory read
//   lcd_cmd[3:0], lcd_cmd_valid, lcd_datain[7:0]    to LCD_CTRL
//   lcd_busy, lcd_output_valid                      from LCD_CTRL
//   seq_idle, cmd_done, err                         sequencer status
interface lcd_cmd_seq_if;
  logic [3:0] host_cmd;
  logic       host_cmd_valid;
  logic       host_cmd_ready;
  logic       img_rd;
  logic [6:0] img_addr;
  logic [7:0] img_data;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       lcd_busy;
  logic       lcd_output_valid;
  logic       seq_idle;
  logic       cmd_done;
  logic       err;

  modport slave (
    input  host_cmd, host_cmd_valid, img_data, lcd_busy, lcd_output_valid,
    output host_cmd_ready, img_rd, img_addr, lcd_cmd, lcd_cmd_valid,
           lcd_datain, seq_idle, cmd_done, err
  );

  modport master (
    output host_cmd, host_cmd_valid, img_data, lcd_busy, lcd_output_valid,
    input  host_cmd_ready, img_rd, img_addr, lcd_cmd, lcd_cmd_valid,
           lcd_datain, seq_idle, cmd_done, err
  );
endinterface

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: command sequencer in front of LCD_CTRL. Host commands are
// buffered in a small FIFO and issued one at a time when LCD_CTRL is not
// busy. A Load command (code 0) streams IMG_N image bytes from an external
// memory into lcd_datain. Each command then waits for OUT_PER_CMD
// lcd_output_valid pulses before cmd_done is pulsed.
// Ports:
//   clk    system clock (rising edge)
//   reset  asynchronous active-low reset
//   bus    lcd_cmd_seq_if.slave (host, image memory, LCD_CTRL, status)
// Build option: define LCD_SEQ_WDOG_EN to add a 12-bit WAIT watchdog that
// sets err, flushes the FIFO and returns to IDLE without cmd_done.
module lcd_cmd_seq #(
  parameter int unsigned IMG_N       = 108,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned OUT_PER_CMD = 16
) (
  input  logic         clk,
  input  logic         reset,
  lcd_cmd_seq_if.slave bus
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [6:0]  LD_LAST  = 7'(IMG_N);
  localparam logic [4:0]  OUT_TGT  = 5'(OUT_PER_CMD);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full, push, issue, is_load;
  logic [3:0]    head;
  logic [6:0]    ld_cnt;
  logic [4:0]    out_cnt;
  logic          wait_done, wdog_trip, err_q, err_set;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign head       = fifo_mem[rd_ptr];
  assign push       = bus.host_cmd_valid && !fifo_full;
  assign issue      = (state == S_IDLE) && !fifo_empty && !bus.lcd_busy;
  assign is_load    = (head == 4'd0);
  assign wait_done  = (state == S_WAIT) && (out_cnt == OUT_TGT) && !bus.lcd_busy;

  // FIFO pointers; a watchdog trip discards everything queued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (wdog_trip) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.host_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (issue) state_nxt = is_load ? S_LOAD : S_WAIT;
      S_LOAD:  if (ld_cnt == LD_LAST) state_nxt = S_WAIT;
      S_WAIT:  if (wait_done || wdog_trip) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address 0 is read in the issue cycle, so LOAD starts at address 1 and
  // its last cycle only forwards the byte read one cycle earlier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               ld_cnt <= '0;
    else if (issue)           ld_cnt <= 7'd1;
    else if (state == S_LOAD) ld_cnt <= ld_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_cnt <= '0;
    else if (state != S_WAIT || wait_done || wdog_trip)
      out_cnt <= '0;
    else if (bus.lcd_output_valid && out_cnt != '1)
      out_cnt <= out_cnt + 1'b1;
  end

  // A pulse arriving once the target is already reached is an excess pulse
  assign err_set = wdog_trip ||
                   (bus.lcd_output_valid && (state != S_WAIT || out_cnt >= OUT_TGT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

`ifdef LCD_SEQ_WDOG_EN
  logic [11:0] wdog;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      wdog <= '0;
    else if (state != S_WAIT || bus.lcd_output_valid) wdog <= '0;
    else                                             wdog <= wdog + 1'b1;
  end

  // Trips in the cycle the WAIT dwell count reaches 4095; a command that
  // completes in that same cycle is treated as a normal completion.
  assign wdog_trip = (state == S_WAIT) && (wdog == 12'd4094) &&
                     !bus.lcd_output_valid && !wait_done;
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    bus.lcd_cmd       = '0;
    bus.lcd_cmd_valid = 1'b0;
    bus.img_rd        = 1'b0;
    bus.img_addr      = '0;
    bus.lcd_datain    = '0;
    if (issue) begin
      bus.lcd_cmd       = head;
      bus.lcd_cmd_valid = 1'b1;
      bus.img_rd        = is_load;
    end
    if (state == S_LOAD) begin
      bus.lcd_datain = bus.img_data;
      if (ld_cnt < LD_LAST) begin
        bus.img_rd   = 1'b1;
        bus.img_addr = ld_cnt;
      end
    end
    bus.cmd_done       = wait_done;
    bus.seq_idle       = (state == S_IDLE) && fifo_empty;
    bus.host_cmd_ready = !fifo_full;
    bus.err            = err_q;
  end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
module tb_lcd_cmd_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  lcd_cmd_seq_if bus();

  lcd_cmd_seq #(.IMG_N(108), .FIFO_DEPTH(4), .OUT_PER_CMD(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] img_mem [128];
  logic [3:0] exp_q [$];

  // Image memory: registered read, junk on the bus when not being read
  always @(posedge clk) bus.img_data <= bus.img_rd ? img_mem[bus.img_addr] : 8'($urandom);

  initial begin
    #10000000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.host_cmd = '0; bus.host_cmd_valid = 1'b0;
    bus.lcd_busy = 1'b0; bus.lcd_output_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b1;
  endtask

  // LCD_CTRL output model: n pulses with random gaps; counts any cmd_done or
  // lcd_cmd_valid seen meanwhile
  task automatic send_pulses(input int n, input bit hold_busy, output int stray);
    int gap;
    stray = 0;
    for (int p = 0; p < n; p++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); bus.lcd_output_valid = 1'b0;
        bus.lcd_busy = hold_busy ? 1'b1 : 1'($urandom_range(0, 1)); #1;
        if (bus.cmd_done || bus.lcd_cmd_valid) stray++;
      end
      @(negedge clk); bus.lcd_output_valid = 1'b1;
      bus.lcd_busy = hold_busy ? 1'b1 : 1'($urandom_range(0, 1)); #1;
      if (bus.cmd_done || bus.lcd_cmd_valid) stray++;
    end
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = -1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk); bus.lcd_output_valid = 1'b0; bus.lcd_busy = 1'b0; #1;
      if (bus.cmd_done) begin cycles = c; break; end
    end
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1; #2; reset = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    total_cnt++; if (bus.seq_idle !== 1'b1) $display("FAIL reset_seq_idle: got %b exp 1", bus.seq_idle); else pass_cnt++;
    total_cnt++; if (bus.host_cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", bus.host_cmd_ready); else pass_cnt++;
    total_cnt++;
    if ({bus.img_rd, bus.img_addr, bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.cmd_done, bus.err} !== '0)
      $display("FAIL reset_outputs: got %h exp 0",
               {bus.img_rd, bus.img_addr, bus.lcd_cmd, bus.lcd_cmd_valid, bus.lcd_datain, bus.cmd_done, bus.err});
    else pass_cnt++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_load();
    int stray, c;
    for (int a = 0; a < 128; a++) img_mem[a] = 8'(a + 1);
    @(negedge clk); bus.host_cmd = 4'd0; bus.host_cmd_valid = 1'b1; bus.lcd_busy = 1'b0; #1;
    total_cnt++; if (bus.host_cmd_ready !== 1'b1) $display("FAIL load_ready: got %b exp 1", bus.host_cmd_ready); else pass_cnt++;
    @(negedge clk); bus.host_cmd_valid = 1'b0; #1;
    total_cnt++; if ({bus.lcd_cmd_valid, bus.lcd_cmd} !== 5'b1_0000) $display("FAIL load_issue: got %b/%h exp 1/0", bus.lcd_cmd_valid, bus.lcd_cmd); else pass_cnt++;
    total_cnt++; if ({bus.img_rd, bus.img_addr} !== 8'h80) $display("FAIL load_first_rd: got %b/%0d exp 1/0", bus.img_rd, bus.img_addr); else pass_cnt++;
    total_cnt++; if (bus.lcd_datain !== 8'h00) $display("FAIL load_issue_datain: got %h exp 00", bus.lcd_datain); else pass_cnt++;
    for (int k = 1; k <= 108; k++) begin
      @(negedge clk); #1;
      total_cnt++; if (bus.lcd_datain !== 8'(k)) $display("FAIL load_datain[%0d]: got %h exp %h", k, bus.lcd_datain, 8'(k)); else pass_cnt++;
      total_cnt++; if (bus.lcd_cmd_valid !== 1'b0) $display("FAIL load_extra_valid[%0d]: got 1 exp 0", k); else pass_cnt++;
      total_cnt++;
      if (bus.img_rd !== (k < 108) || (k < 108 && bus.img_addr !== 7'(k)))
        $display("FAIL load_rd[%0d]: got %b/%0d exp %b/%0d", k, bus.img_rd, bus.img_addr, k < 108, k);
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++; if ({bus.img_rd, bus.lcd_datain} !== 9'h0) $display("FAIL load_end_idle: got %b/%h exp 0/00", bus.img_rd, bus.lcd_datain); else pass_cnt++;
    send_pulses(16, 1'b0, stray);
    total_cnt++; if (stray !== 0) $display("FAIL load_stray: got %0d exp 0", stray); else pass_cnt++;
    wait_done(4, c);
    total_cnt++; if (c !== 1) $display("FAIL load_done: got %0d exp 1", c); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL load_err: got %b exp 0", bus.err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int stray, c, extra;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); bus.lcd_busy = 1'b1; bus.host_cmd = 4'(i); bus.host_cmd_valid = 1'b1; #1;
      total_cnt++; if (bus.host_cmd_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b exp 1", i, bus.host_cmd_ready); else pass_cnt++;
    end
    @(negedge clk); bus.host_cmd = 4'd9; #1;
    total_cnt++; if (bus.host_cmd_ready !== 1'b0) $display("FAIL b2b_full: got %b exp 0", bus.host_cmd_ready); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); bus.host_cmd_valid = 1'b0; bus.lcd_busy = 1'b0; #1;
      total_cnt++;
      if ({bus.lcd_cmd_valid, bus.lcd_cmd} !== {1'b1, 4'(i)}) $display("FAIL b2b_issue[%0d]: got %b/%h exp 1/%h", i, bus.lcd_cmd_valid, bus.lcd_cmd, i);
      else pass_cnt++;
      send_pulses(16, 1'b0, stray);
      total_cnt++; if (stray !== 0) $display("FAIL b2b_stray[%0d]: got %0d exp 0", i, stray); else pass_cnt++;
      wait_done(4, c);
      total_cnt++; if (c !== 1) $display("FAIL b2b_done[%0d]: got %0d exp 1", i, c); else pass_cnt++;
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.lcd_busy = 1'b0; #1;
      if (bus.lcd_cmd_valid || !bus.seq_idle) extra++;
    end
    total_cnt++; if (extra !== 0) $display("FAIL b2b_dropped_5th: got %0d exp 0", extra); else pass_cnt++;
  endtask

  task automatic test_busy_holdoff();
    int stray, c, seen;
    @(negedge clk); bus.lcd_busy = 1'b1; bus.host_cmd = 4'd5; bus.host_cmd_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); bus.host_cmd_valid = 1'b0; bus.lcd_busy = 1'b1; #1;
      if (bus.lcd_cmd_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL busy_holdoff: got %0d exp 0", seen); else pass_cnt++;
    @(negedge clk); bus.lcd_busy = 1'b0; #1;
    total_cnt++; if ({bus.lcd_cmd_valid, bus.lcd_cmd} !== 5'b1_0101) $display("FAIL busy_release_issue: got %b/%h exp 1/5", bus.lcd_cmd_valid, bus.lcd_cmd); else pass_cnt++;
    send_pulses(16, 1'b0, stray);
    wait_done(4, c);
    total_cnt++; if (c !== 1 || stray !== 0) $display("FAIL busy_done: got %0d/%0d exp 1/0", c, stray); else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int N = 10;
    for (int a = 0; a < 128; a++) img_mem[a] = 8'($urandom);
    exp_q.delete();
    fork
      begin
        int sent = 0;
        int guard = 0;
        while (sent < N && guard < 20000) begin
          @(negedge clk); guard++;
          bus.host_cmd_valid = ($urandom_range(0, 3) == 0);
          bus.host_cmd = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
          #1;
          if (bus.host_cmd_valid && bus.host_cmd_ready) begin exp_q.push_back(bus.host_cmd); sent++; end
        end
        @(negedge clk); bus.host_cmd_valid = 1'b0;
      end
      begin
        int done_n = 0;
        int guard = 0;
        int stray, c;
        logic [3:0] exp_cmd;
        while (done_n < N && guard < 20000) begin
          @(negedge clk); guard++;
          bus.lcd_busy = ($urandom_range(0, 3) == 0); bus.lcd_output_valid = 1'b0; #1;
          if (bus.lcd_cmd_valid) begin
            total_cnt++; if (bus.lcd_busy !== 1'b0) $display("FAIL rand_issue_busy: got 1 exp 0"); else pass_cnt++;
            exp_cmd = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            total_cnt++; if (bus.lcd_cmd !== exp_cmd) $display("FAIL rand_order: got %h exp %h", bus.lcd_cmd, exp_cmd); else pass_cnt++;
            if (exp_cmd == 4'd0) begin
              for (int k = 1; k <= 108; k++) begin
                @(negedge clk); bus.lcd_busy = 1'($urandom_range(0, 1)); #1;
                total_cnt++; if (bus.lcd_datain !== img_mem[k-1]) $display("FAIL rand_datain[%0d]: got %h exp %h", k, bus.lcd_datain, img_mem[k-1]); else pass_cnt++;
              end
            end
            send_pulses(16, 1'b0, stray);
            wait_done(4, c);
            total_cnt++; if (c !== 1 || stray !== 0) $display("FAIL rand_done: got %0d/%0d exp 1/0", c, stray); else pass_cnt++;
            done_n++;
          end
        end
        total_cnt++; if (done_n !== N) $display("FAIL rand_completed: got %0d exp %0d", done_n, N); else pass_cnt++;
      end
    join
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL rand_err: got %b exp 0", bus.err); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    int issues;
    for (int a = 0; a < 128; a++) img_mem[a] = 8'(a + 1);
    @(negedge clk); bus.lcd_busy = 1'b1; bus.host_cmd = 4'd0; bus.host_cmd_valid = 1'b1;
    @(negedge clk); bus.host_cmd = 4'd6;
    @(negedge clk); bus.host_cmd_valid = 1'b0; bus.lcd_busy = 1'b0; #1;
    total_cnt++; if (bus.lcd_cmd_valid !== 1'b1) $display("FAIL mid_issue: got %b exp 1", bus.lcd_cmd_valid); else pass_cnt++;
    repeat (50) @(negedge clk);
    reset = 1'b0; #1;
    total_cnt++;
    if ({bus.img_rd, bus.lcd_datain, bus.seq_idle, bus.host_cmd_ready} !== 11'b0_00000000_1_1)
      $display("FAIL mid_reset_outputs: got %b/%h/%b/%b exp 0/00/1/1", bus.img_rd, bus.lcd_datain, bus.seq_idle, bus.host_cmd_ready);
    else pass_cnt++;
    @(negedge clk); reset = 1'b1;
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.lcd_busy = 1'b0; #1;
      if (bus.lcd_cmd_valid) issues++;
    end
    total_cnt++; if (issues !== 0) $display("FAIL mid_flush: got %0d exp 0", issues); else pass_cnt++;
  endtask

  task automatic test_error();
    int stray;
    @(negedge clk); bus.lcd_busy = 1'b0; bus.host_cmd = 4'd7; bus.host_cmd_valid = 1'b1;
    @(negedge clk); bus.host_cmd_valid = 1'b0; #1;
    total_cnt++; if (bus.lcd_cmd_valid !== 1'b1) $display("FAIL err_issue: got %b exp 1", bus.lcd_cmd_valid); else pass_cnt++;
    send_pulses(16, 1'b1, stray);
    @(negedge clk); bus.lcd_output_valid = 1'b0; #1;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL err_at_16: got %b exp 0", bus.err); else pass_cnt++;
    send_pulses(1, 1'b1, stray);
    @(negedge clk); bus.lcd_output_valid = 1'b0; #1;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL err_excess: got %b exp 1", bus.err); else pass_cnt++;
    repeat (10) begin @(negedge clk); bus.lcd_busy = 1'b0; end
    #1;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", bus.err); else pass_cnt++;
    do_reset(); #1;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL err_cleared: got %b exp 0", bus.err); else pass_cnt++;
    @(negedge clk); bus.lcd_output_valid = 1'b1;
    @(negedge clk); bus.lcd_output_valid = 1'b0; #1;
    total_cnt++; if (bus.err !== 1'b1) $display("FAIL err_idle_pulse: got %b exp 1", bus.err); else pass_cnt++;
    do_reset();
  endtask

`ifdef LCD_SEQ_WDOG_EN
  task automatic test_watchdog();
    int bad;
    @(negedge clk); bus.lcd_busy = 1'b0; bus.host_cmd = 4'd1; bus.host_cmd_valid = 1'b1;
    @(negedge clk); bus.host_cmd_valid = 1'b0; #1;
    total_cnt++; if (bus.lcd_cmd_valid !== 1'b1) $display("FAIL wdog_issue: got %b exp 1", bus.lcd_cmd_valid); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 4095; k++) begin
      @(negedge clk); bus.lcd_busy = 1'b1;
      bus.host_cmd = 4'd2; bus.host_cmd_valid = (k == 3); #1;
      if (bus.seq_idle || bus.err || bus.cmd_done) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL wdog_early: got %0d exp 0", bad); else pass_cnt++;
    @(negedge clk); bus.host_cmd_valid = 1'b0; #1;
    total_cnt++;
    if ({bus.seq_idle, bus.err, bus.cmd_done} !== 3'b110)
      $display("FAIL wdog_trip: got %b%b%b exp 110", bus.seq_idle, bus.err, bus.cmd_done);
    else pass_cnt++;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_busy_holdoff();
    test_random();
    test_reset_midstream();
    test_error();
`ifdef LCD_SEQ_WDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
